// File: rtl/ramio_port_arbiter_pkg.sv
// Shared RAMIO port-A definitions: access encodings and the request bundle
// used by the core, the secondary master path and RAMIO itself.
package ramio_port_arbiter_pkg;

   // Write-enable encodings (size of the store).
   typedef enum logic [1:0] {
      WE_NONE = 2'b00,
      WE_BYTE = 2'b01,
      WE_HALF = 2'b10,
      WE_WORD = 2'b11
   } we_e;

   // Read-enable encodings: bit 2 = sign extend, [1:0] = size.
   typedef enum logic [2:0] {
      RE_NONE = 3'b000,
      RE_BU   = 3'b001,
      RE_HU   = 3'b010,
      RE_W    = 3'b011,
      RE_B    = 3'b101,
      RE_H    = 3'b110
   } re_e;

   // Byte-address width carried in the request bundle. Matches the default
   // 8K-word RAMIO (13 word-address bits + 2 byte-offset bits); instances
   // built with a different depth resize at the port boundary.
   localparam int PORTA_ADDR_W = 15;

   // One port-A access as seen on the RAMIO pins.
   typedef struct packed {
      logic [1:0]              we;
      logic [2:0]              re;
      logic [PORTA_ADDR_W-1:0] addr;
      logic [31:0]             din;
   } porta_req_t;

   // An access does something on the port only if it reads or writes.
   function automatic logic req_active(input porta_req_t r);
      return (r.we != WE_NONE) || (r.re != RE_NONE);
   endfunction

endpackage

// File: rtl/ramio_starve_counter.sv
// Starvation guard for the secondary master: counts cycles a pending
// request loses arbitration and forces a single-cycle core stall once it
// has lost MAX_WAIT times in a row. MAX_WAIT = 0 disables the stall.
module ramio_starve_counter
   import ramio_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic s_req,
   input  logic grant_s,
   output logic core_stall
);

   // With MAX_WAIT = 0 the counter is never compared; keep it one bit wide
   // so the declaration stays legal.
   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

   logic [CW-1:0] wait_cnt;
   logic          losing;
   logic          stall_nxt;

   assign losing = s_req && !grant_s;

   // Stall next cycle when this is the MAX_WAIT-th consecutive loss. While
   // stalled, grant_s follows s_req, so losing is 0 and the stall cannot
   // repeat on the following cycle.
   assign stall_nxt = (MAX_WAIT != 0) && losing && (wait_cnt == LAST);

   // Wait counter and registered stall; an idle or granted master restarts
   // the count from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= '0;
         core_stall <= 1'b0;
      end else begin
         core_stall <= stall_nxt;
         if (losing)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

endmodule

// File: rtl/ramio_port_arbiter.sv
// RAMIO port-A arbiter: the core's load/store path owns the port unless it
// is idle or stalled; a secondary master (loader/debug) gets the remaining
// slots, with a forced one-cycle core stall as its progress guarantee.
// Read data is returned one cycle after the access and tagged to its owner.
module ramio_port_arbiter
   import ramio_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // core port
   input  logic [1:0]            c_weA,
   input  logic [2:0]            c_reA,
   input  logic [ADDR_WIDTH+1:0] c_addrA,
   input  logic [31:0]           c_dinA,
   output logic [31:0]           c_doutA,
   output logic                  core_stall,
   // secondary master
   input  logic                  s_req,
   input  logic [1:0]            s_we,
   input  logic [2:0]            s_re,
   input  logic [ADDR_WIDTH+1:0] s_addr,
   input  logic [31:0]           s_din,
   output logic                  s_ack,
   output logic [31:0]           s_dout,
   output logic                  s_rvalid,
   // RAMIO port A
   output logic [1:0]            ram_weA,
   output logic [2:0]            ram_reA,
   output logic [ADDR_WIDTH+1:0] ram_addrA,
   output logic [31:0]           ram_dinA,
   input  logic [31:0]           ram_doutA
);

   localparam int AW     = ADDR_WIDTH + 2;
   localparam int STAGES = 1;   // RAM read latency

   porta_req_t        c_req;
   porta_req_t        s_req_f;
   porta_req_t        port;
   logic              core_active;
   logic              grant_s;
   logic [STAGES:0]   vld_pipe;

   assign c_req   = '{we: c_weA, re: c_reA, addr: PORTA_ADDR_W'(c_addrA), din: c_dinA};
   assign s_req_f = '{we: s_we,  re: s_re,  addr: PORTA_ADDR_W'(s_addr),  din: s_din};

   // A stalled core must not touch the port, so its inputs are masked even
   // if it leaves them nonzero.
   assign core_active = req_active(c_req) && !core_stall;

   // Secondary wins whenever the core is idle, and always in a stall cycle.
   assign grant_s = s_req && (!core_active || core_stall);

   ramio_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk        (clk),
      .rst        (rst),
      .s_req      (s_req),
      .grant_s    (grant_s),
      .core_stall (core_stall)
   );

   // Port mux: secondary on grant, else the active core, else all zero.
   always_comb begin
      port  = '0;
      s_ack = 1'b0;
      if (grant_s) begin
         port  = s_req_f;
         s_ack = 1'b1;
      end else if (core_active) begin
         port  = c_req;
      end
   end

   assign ram_weA   = port.we;
   assign ram_reA   = port.re;
   assign ram_addrA = AW'(port.addr);
   assign ram_dinA  = port.din;

   // Read tag: a granted secondary access with any read enable owns the
   // data that comes back STAGES cycles later. An invalid request (no
   // enables) is acked but never produces s_rvalid.
   assign vld_pipe[0] = grant_s && (s_re != RE_NONE);

   // Shift the tag along with the RAM read latency.
   always_ff @(posedge clk) begin
      if (rst)
         vld_pipe[STAGES:1] <= '0;
      else
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   assign s_rvalid = vld_pipe[STAGES];
   assign s_dout   = s_rvalid ? ram_doutA : 32'h0;

   // The core only consumes read data after its own load, so no gating.
   assign c_doutA  = ram_doutA;

endmodule

// File: tb/tb_ramio_port_arbiter.sv
// Directed bench for ramio_port_arbiter: one instance with MAX_WAIT = 8
// attached to a behavioural RAMIO port-A model, plus a MAX_WAIT = 0
// instance sharing the same inputs for the stall-disabled case.
module tb_ramio_port_arbiter;
   import ramio_port_arbiter_pkg::*;

   localparam int AW = 13;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]    c_weA;
   logic [2:0]    c_reA;
   logic [AW+1:0] c_addrA;
   logic [31:0]   c_dinA;
   logic          s_req;
   logic [1:0]    s_we;
   logic [2:0]    s_re;
   logic [AW+1:0] s_addr;
   logic [31:0]   s_din;

   logic [31:0]   c_doutA, s_dout, ram_dinA;
   logic          core_stall, s_ack, s_rvalid;
   logic [1:0]    ram_weA;
   logic [2:0]    ram_reA;
   logic [AW+1:0] ram_addrA;
   logic [31:0]   ram_doutA = 32'h0;

   logic [31:0]   z_c_doutA, z_s_dout, z_ram_dinA;
   logic          z_core_stall, z_s_ack, z_s_rvalid;
   logic [1:0]    z_ram_weA;
   logic [2:0]    z_ram_reA;
   logic [AW+1:0] z_ram_addrA;
   logic [31:0]   z_ram_doutA = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   ramio_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst),
      .c_weA(c_weA), .c_reA(c_reA), .c_addrA(c_addrA), .c_dinA(c_dinA),
      .c_doutA(c_doutA), .core_stall(core_stall),
      .s_req(s_req), .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_din(s_din),
      .s_ack(s_ack), .s_dout(s_dout), .s_rvalid(s_rvalid),
      .ram_weA(ram_weA), .ram_reA(ram_reA), .ram_addrA(ram_addrA),
      .ram_dinA(ram_dinA), .ram_doutA(ram_doutA)
   );

   ramio_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .c_weA(c_weA), .c_reA(c_reA), .c_addrA(c_addrA), .c_dinA(c_dinA),
      .c_doutA(z_c_doutA), .core_stall(z_core_stall),
      .s_req(s_req), .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_din(s_din),
      .s_ack(z_s_ack), .s_dout(z_s_dout), .s_rvalid(z_s_rvalid),
      .ram_weA(z_ram_weA), .ram_reA(z_ram_reA), .ram_addrA(z_ram_addrA),
      .ram_dinA(z_ram_dinA), .ram_doutA(z_ram_doutA)
   );

   // Behavioural RAMIO port A: sized writes, registered sized reads.
   logic [31:0] mem [0:255];
   logic [7:0]  widx;
   assign widx = ram_addrA[9:2];

   function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] re,
                                          input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*a +: 8];
      h = w[16*a[1] +: 16];
      case (re[1:0])
         2'b01:   return re[2] ? {{24{b[7]}}, b} : {24'h0, b};
         2'b10:   return re[2] ? {{16{h[15]}}, h} : {16'h0, h};
         default: return w;
      endcase
   endfunction

   always @(posedge clk) begin
      case (ram_weA)
         2'b01:   mem[widx][8*ram_addrA[1:0] +: 8] <= ram_dinA[7:0];
         2'b10:   mem[widx][16*ram_addrA[1] +: 16] <= ram_dinA[15:0];
         2'b11:   mem[widx] <= ram_dinA;
         default: ;
      endcase
      if (ram_reA != 3'b000)
         ram_doutA <= rd_fmt(mem[widx], ram_reA, ram_addrA[1:0]);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic core_idle();
      c_weA = WE_NONE; c_reA = RE_NONE; c_addrA = '0; c_dinA = '0;
   endtask

   task automatic sec_idle();
      s_req = 1'b0; s_we = WE_NONE; s_re = RE_NONE; s_addr = '0; s_din = '0;
   endtask

   task automatic sec_sw(input logic [AW+1:0] a, input logic [31:0] d);
      s_req = 1'b1; s_we = WE_WORD; s_re = RE_NONE; s_addr = a; s_din = d;
   endtask

   task automatic sec_lw(input logic [AW+1:0] a);
      s_req = 1'b1; s_we = WE_NONE; s_re = RE_W; s_addr = a; s_din = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      core_idle();
      sec_idle();
      step(); step();
      rst = 1'b0;
      settle();

      // reset state
      chk("rst_core_stall", 32'(core_stall), 32'd0);
      chk("rst_s_rvalid",   32'(s_rvalid),   32'd0);
      chk("rst_s_ack",      32'(s_ack),      32'd0);
      chk("rst_wait_cnt",   32'(dut.u_starve.wait_cnt), 32'd0);
      chk("rst_ram_we",     32'(ram_weA),    32'd0);

      // idle core: SW then LW through the secondary
      step(); sec_sw(15'h0040, 32'hDEADBEEF); settle();
      chk("idle_sw_ack",  32'(s_ack),     32'd1);
      chk("idle_sw_we",   32'(ram_weA),   32'd3);
      chk("idle_sw_addr", 32'(ram_addrA), 32'h40);
      chk("idle_sw_din",  ram_dinA,       32'hDEADBEEF);
      step(); sec_lw(15'h0040); settle();
      chk("idle_lw_ack",  32'(s_ack),     32'd1);
      chk("idle_lw_re",   32'(ram_reA),   32'd3);
      chk("idle_lw_rv0",  32'(s_rvalid),  32'd0);
      step(); sec_idle(); settle();
      chk("idle_lw_rv1",  32'(s_rvalid),  32'd1);
      chk("idle_lw_dout", s_dout,         32'hDEADBEEF);
      chk("idle_ack_off", 32'(s_ack),     32'd0);

      // read tagging: core LBU 0x41, then secondary LW 0x40
      step(); c_reA = RE_BU; c_addrA = 15'h0041; settle();
      chk("tag_core_re",   32'(ram_reA),   32'd1);
      chk("tag_core_addr", 32'(ram_addrA), 32'h41);
      step(); core_idle(); sec_lw(15'h0040); settle();
      chk("tag_c_dout",  c_doutA,         32'h000000BE);
      chk("tag_rv0",     32'(s_rvalid),   32'd0);
      chk("tag_sdout0",  s_dout,          32'h0);
      chk("tag_ack",     32'(s_ack),      32'd1);
      step(); sec_idle(); settle();
      chk("tag_rv1",     32'(s_rvalid),   32'd1);
      chk("tag_sdout1",  s_dout,          32'hDEADBEEF);

      // core signed byte load: 0xDE sign-extended
      step(); c_reA = RE_B; c_addrA = 15'h0043; settle();
      chk("lb_re", 32'(ram_reA), 32'd5);
      step(); core_idle(); settle();
      chk("lb_dout", c_doutA, 32'hFFFFFFDE);
      chk("lb_rv",   32'(s_rvalid), 32'd0);

      // invalid secondary request: acked no-op
      step(); s_req = 1'b1; s_addr = 15'h0040; settle();
      chk("inv_ack", 32'(s_ack),   32'd1);
      chk("inv_we",  32'(ram_weA), 32'd0);
      chk("inv_re",  32'(ram_reA), 32'd0);
      step(); sec_idle(); settle();
      chk("inv_rv",  32'(s_rvalid), 32'd0);

      // contention: core LW every cycle, secondary SW held
      step(); c_reA = RE_W; c_addrA = 15'h0080; sec_sw(15'h007C, 32'h12345678); settle();
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("cont_ack_c%0d", i),   32'(s_ack),        32'd0);
         chk($sformatf("cont_stall_c%0d", i), 32'(core_stall),   32'd0);
         chk($sformatf("cont_re_c%0d", i),    32'(ram_reA),      32'd3);
         chk($sformatf("nost_stall_c%0d", i), 32'(z_core_stall), 32'd0);
         chk($sformatf("nost_ack_c%0d", i),   32'(z_s_ack),      32'd0);
         step(); settle();
      end
      chk("cont_stall_c9", 32'(core_stall), 32'd1);
      chk("cont_ack_c9",   32'(s_ack),      32'd1);
      chk("cont_mask_re",  32'(ram_reA),    32'd0);
      chk("cont_we_c9",    32'(ram_weA),    32'd3);
      chk("cont_addr_c9",  32'(ram_addrA),  32'h7C);
      chk("nost_stall_c9", 32'(z_core_stall), 32'd0);
      chk("nost_ack_c9",   32'(z_s_ack),    32'd0);
      step(); sec_idle(); settle();
      chk("cont_stall_c10", 32'(core_stall), 32'd0);
      chk("cont_re_c10",    32'(ram_reA),    32'd3);
      chk("cont_ack_c10",   32'(s_ack),      32'd0);

      // stall disabled: long busy stretch on the MAX_WAIT = 0 instance
      step(); sec_sw(15'h007C, 32'h12345678); settle();
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("dis_stall_%0d", i), 32'(z_core_stall), 32'd0);
         chk($sformatf("dis_ack_%0d", i),   32'(z_s_ack),      32'd0);
         step(); settle();
      end
      core_idle(); settle();
      chk("dis_ack_idle", 32'(z_s_ack), 32'd1);
      step(); sec_idle(); settle();

      // reset mid-operation: 5 lost cycles, then reset on a would-be read grant
      step(); c_reA = RE_W; c_addrA = 15'h0080; sec_sw(15'h007C, 32'h12345678); settle();
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("mid_ack_c%0d", i), 32'(s_ack), 32'd0);
         step(); settle();
      end
      chk("mid_wait_cnt5", 32'(dut.u_starve.wait_cnt), 32'd5);
      rst = 1'b1; core_idle(); sec_lw(15'h0040); settle();
      step(); rst = 1'b0; c_reA = RE_W; c_addrA = 15'h0080; sec_sw(15'h007C, 32'h12345678); settle();
      chk("mid_rst_stall", 32'(core_stall), 32'd0);
      chk("mid_rst_rv",    32'(s_rvalid),   32'd0);
      chk("mid_rst_cnt",   32'(dut.u_starve.wait_cnt), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("mid_re_ack_c%0d", i), 32'(s_ack), 32'd0);
         step(); settle();
      end
      chk("mid_re_stall_c9", 32'(core_stall), 32'd1);
      chk("mid_re_ack_c9",   32'(s_ack),      32'd1);
      step(); core_idle(); sec_idle(); settle();

      // back-to-back writes with readback
      step(); sec_sw(15'h0100, 32'hA1A10001); settle();
      chk("b2b_ack0", 32'(s_ack), 32'd1);
      step(); sec_sw(15'h0104, 32'hB2B20002); settle();
      chk("b2b_ack1", 32'(s_ack), 32'd1);
      step(); sec_sw(15'h0108, 32'hC3C30003); settle();
      chk("b2b_ack2", 32'(s_ack), 32'd1);
      step(); sec_lw(15'h0100); settle();
      chk("b2b_rd_ack0", 32'(s_ack), 32'd1);
      step(); sec_lw(15'h0104); settle();
      chk("b2b_rv0",   32'(s_rvalid), 32'd1);
      chk("b2b_dout0", s_dout, 32'hA1A10001);
      step(); sec_lw(15'h0108); settle();
      chk("b2b_dout1", s_dout, 32'hB2B20002);
      step(); sec_idle(); settle();
      chk("b2b_rv2",   32'(s_rvalid), 32'd1);
      chk("b2b_dout2", s_dout, 32'hC3C30003);
      step(); settle();
      chk("b2b_rv_off",   32'(s_rvalid), 32'd0);
      chk("b2b_dout_off", s_dout, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
